// File: rtl/cookie_mem_pkg.sv
// Types and sizes shared by the SDRAM port arbiter and the SDRAM controller.
package cookie_mem_pkg;

  localparam int unsigned NUM_REQ = 3;
  localparam int unsigned ADDR_W  = 25;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned LEN_W   = 4;

  typedef enum logic [1:0] {
    REQ_VGA = 2'd0,
    REQ_INS = 2'd1,
    REQ_DAT = 2'd2
  } req_id_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_BURST
  } arb_state_t;

endpackage

// File: rtl/arb_select.sv
// Owner pick: VGA has absolute priority; INS/DAT ties go to whichever did not win last.
module arb_select
  import cookie_mem_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_valid,
  input  req_id_t            last_cpu,
  output req_id_t            pick,
  output logic               any
);

  always_comb begin
    pick = REQ_VGA;
    if (req_valid[REQ_VGA]) begin
      pick = REQ_VGA;
    end else if (req_valid[REQ_INS] && req_valid[REQ_DAT]) begin
      pick = (last_cpu == REQ_INS) ? REQ_DAT : REQ_INS;
    end else if (req_valid[REQ_INS]) begin
      pick = REQ_INS;
    end else if (req_valid[REQ_DAT]) begin
      pick = REQ_DAT;
    end
  end

  assign any = |req_valid;

endmodule

// File: rtl/dram_port_arbiter.sv
// Shares the SDRAM controller command port between VGA, instruction fetch and data
// clients; one burst in flight, data steered combinationally to the current owner.
module dram_port_arbiter #(
  parameter int unsigned ADDR_W = cookie_mem_pkg::ADDR_W,
  parameter int unsigned DATA_W = cookie_mem_pkg::DATA_W,
  parameter int unsigned LEN_W  = cookie_mem_pkg::LEN_W
) (
  input  logic                   main_clk,
  input  logic                   reset,
  input  logic [2:0]             req_valid,
  output logic [2:0]             req_ready,
  input  logic [2:0][ADDR_W-1:0] req_addr,
  input  logic [2:0]             req_write,
  input  logic [2:0][LEN_W-1:0]  req_len,
  input  logic [2:0][DATA_W-1:0] req_wr_data,
  output logic [2:0]             wr_accept,
  output logic [2:0]             rd_valid,
  output logic [DATA_W-1:0]      rd_data,
  output logic [2:0]             done,
  output logic                   mem_cmd_valid,
  input  logic                   mem_cmd_ready,
  output logic [ADDR_W-1:0]      mem_cmd_addr,
  output logic                   mem_cmd_write,
  output logic [LEN_W-1:0]       mem_cmd_len,
  output logic [DATA_W-1:0]      mem_wr_data,
  input  logic                   mem_wr_accept,
  input  logic                   mem_rd_valid,
  input  logic [DATA_W-1:0]      mem_rd_data,
  input  logic                   mem_done
);

  import cookie_mem_pkg::*;

  arb_state_t        state_q;
  req_id_t           owner_q;
  req_id_t           last_cpu_q;
  req_id_t           pick;
  logic              any;
  logic [ADDR_W-1:0] cmd_addr_q;
  logic              cmd_write_q;
  logic [LEN_W-1:0]  cmd_len_q;

  arb_select u_arb_select (
    .req_valid (req_valid),
    .last_cpu  (last_cpu_q),
    .pick      (pick),
    .any       (any)
  );

  always_ff @(posedge main_clk) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      owner_q     <= REQ_VGA;
      last_cpu_q  <= REQ_DAT;
      cmd_addr_q  <= '0;
      cmd_write_q <= 1'b0;
      cmd_len_q   <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (any) begin
            owner_q     <= pick;
            cmd_addr_q  <= req_addr[pick];
            // The VGA fetcher only ever reads, whatever its write bit says.
            cmd_write_q <= req_write[pick] && (pick != REQ_VGA);
            cmd_len_q   <= req_len[pick];
            state_q     <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          if (mem_cmd_ready) begin
            state_q <= ARB_BURST;
            if (owner_q != REQ_VGA) last_cpu_q <= owner_q;
          end
        end
        ARB_BURST: begin
          if (mem_done) state_q <= ARB_IDLE;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign mem_cmd_valid = (state_q == ARB_ISSUE);
  assign mem_cmd_addr  = cmd_addr_q;
  assign mem_cmd_write = cmd_write_q;
  assign mem_cmd_len   = cmd_len_q;

  // Controller-side strobes are only meaningful during the owner's burst.
  always_comb begin
    req_ready   = '0;
    wr_accept   = '0;
    rd_valid    = '0;
    done        = '0;
    rd_data     = '0;
    mem_wr_data = '0;
    if (state_q == ARB_ISSUE && mem_cmd_ready) begin
      req_ready[owner_q] = 1'b1;
    end
    if (state_q == ARB_BURST) begin
      mem_wr_data        = req_wr_data[owner_q];
      wr_accept[owner_q] = mem_wr_accept;
      rd_valid[owner_q]  = mem_rd_valid;
      rd_data            = mem_rd_data;
      done[owner_q]      = mem_done;
    end
  end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Scoreboard bench for dram_port_arbiter: stimulus pushes expected grants/data/done,
// a negedge monitor pops and compares whenever the DUT presents a strobe.
module tb_dram_port_arbiter;
  import cookie_mem_pkg::*;

  localparam int AW = 25;
  localparam int DW = 16;
  localparam int LW = 4;

  logic              main_clk = 1'b0;
  logic              reset = 1'b1;
  logic [2:0]        req_valid = '0;
  logic [2:0]        req_ready;
  logic [2:0][AW-1:0] req_addr = '0;
  logic [2:0]        req_write = '0;
  logic [2:0][LW-1:0] req_len = '0;
  logic [2:0][DW-1:0] req_wr_data = '0;
  logic [2:0]        wr_accept;
  logic [2:0]        rd_valid;
  logic [DW-1:0]     rd_data;
  logic [2:0]        done;
  logic              mem_cmd_valid;
  logic              mem_cmd_ready = 1'b0;
  logic [AW-1:0]     mem_cmd_addr;
  logic              mem_cmd_write;
  logic [LW-1:0]     mem_cmd_len;
  logic [DW-1:0]     mem_wr_data;
  logic              mem_wr_accept = 1'b0;
  logic              mem_rd_valid = 1'b0;
  logic [DW-1:0]     mem_rd_data = '0;
  logic              mem_done = 1'b0;

  always #5 main_clk = ~main_clk;

  dram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .main_clk      (main_clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_write     (req_write),
    .req_len       (req_len),
    .req_wr_data   (req_wr_data),
    .wr_accept     (wr_accept),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .done          (done),
    .mem_cmd_valid (mem_cmd_valid),
    .mem_cmd_ready (mem_cmd_ready),
    .mem_cmd_addr  (mem_cmd_addr),
    .mem_cmd_write (mem_cmd_write),
    .mem_cmd_len   (mem_cmd_len),
    .mem_wr_data   (mem_wr_data),
    .mem_wr_accept (mem_wr_accept),
    .mem_rd_valid  (mem_rd_valid),
    .mem_rd_data   (mem_rd_data),
    .mem_done      (mem_done)
  );

  typedef struct {
    int          idx;
    logic [15:0] data;
  } xfer_t;

  int    n_checks = 0;
  int    n_fail = 0;
  xfer_t rd_q[$];
  xfer_t wr_q[$];
  int    grant_q[$];
  int    done_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int oh_idx(input logic [2:0] v);
    case (v)
      3'b001:  return 0;
      3'b010:  return 1;
      3'b100:  return 2;
      default: return -1;
    endcase
  endfunction

  // Monitor
  always @(negedge main_clk) begin
    if (!reset) begin
      if (req_ready != 3'b000) begin
        if (grant_q.size() == 0) check("unexpected_grant", 64'(req_ready), 64'd0);
        else begin
          int e;
          e = grant_q.pop_front();
          check("grant_owner", 64'(oh_idx(req_ready)), 64'(e));
        end
      end
      if (rd_valid != 3'b000) begin
        if (rd_q.size() == 0) check("unexpected_rd", 64'(rd_valid), 64'd0);
        else begin
          xfer_t x;
          x = rd_q.pop_front();
          check("rd_owner", 64'(oh_idx(rd_valid)), 64'(x.idx));
          check("rd_data", 64'(rd_data), 64'(x.data));
        end
      end
      if (wr_accept != 3'b000) begin
        if (wr_q.size() == 0) check("unexpected_wr", 64'(wr_accept), 64'd0);
        else begin
          xfer_t x;
          x = wr_q.pop_front();
          check("wr_owner", 64'(oh_idx(wr_accept)), 64'(x.idx));
          check("wr_data", 64'(mem_wr_data), 64'(x.data));
        end
      end
      if (done != 3'b000) begin
        if (done_q.size() == 0) check("unexpected_done", 64'(done), 64'd0);
        else begin
          int e;
          e = done_q.pop_front();
          check("done_owner", 64'(oh_idx(done)), 64'(e));
        end
      end
    end
  end

  task automatic tick();
    @(posedge main_clk);
    #1;
  endtask

  task automatic wait_cmd();
    for (int i = 0; i < 200; i++) begin
      @(negedge main_clk);
      if (mem_cmd_valid) return;
    end
    check("cmd_timeout", 64'd0, 64'd1);
  endtask

  task automatic accept_cmd(input int owner);
    grant_q.push_back(owner);
    tick();
    mem_cmd_ready = 1'b1;
    tick();
    mem_cmd_ready = 1'b0;
  endtask

  task automatic read_data(input int owner, input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      tick();
      mem_rd_valid = 1'b1;
      mem_rd_data  = base + 16'(i);
      rd_q.push_back('{owner, base + 16'(i)});
      if (i == n - 1) begin
        mem_done = 1'b1;
        done_q.push_back(owner);
      end
    end
    tick();
    mem_rd_valid = 1'b0;
    mem_rd_data  = '0;
    mem_done     = 1'b0;
  endtask

  task automatic write_data(input int owner, input int n, input logic [15:0] base);
    int k;
    bit acc;
    bit phase;
    k = 0;
    acc = 1'b0;
    phase = 1'b0;
    while (k < n) begin
      tick();
      if (acc) begin
        k++;
        req_wr_data[owner] = base + 16'(k);
      end
      acc = 1'b0;
      if (k < n) begin
        acc = phase;
        if (acc) wr_q.push_back('{owner, base + 16'(k)});
        phase = !phase;
      end
      mem_wr_accept = acc;
    end
    mem_done = 1'b1;
    done_q.push_back(owner);
    tick();
    mem_done = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, 64'({mem_cmd_valid, req_ready, rd_valid, wr_accept, done}), 64'd0);
    check({tag, "_cmd"}, 64'({mem_cmd_addr, mem_cmd_write, mem_cmd_len}), 64'd0);
    check({tag, "_data"}, 64'({rd_data, mem_wr_data}), 64'd0);
  endtask

  initial begin
    // Reset dominates even with requests and controller strobes active.
    req_valid     = 3'b111;
    mem_cmd_ready = 1'b1;
    mem_rd_valid  = 1'b1;
    mem_done      = 1'b1;
    repeat (3) tick();
    @(negedge main_clk);
    check_all_zero("reset");
    check("reset_state", 64'(dut.state_q), 64'(ARB_IDLE));
    req_valid = '0;
    mem_cmd_ready = 1'b0;
    mem_rd_valid = 1'b0;
    mem_done = 1'b0;
    tick();
    reset = 1'b0;

    // INS/DAT round robin, INS first out of reset.
    req_addr[1] = 25'h0001000;
    req_addr[2] = 25'h0002000;
    req_len[1]  = 4'd3;
    req_len[2]  = 4'd3;
    req_valid   = 3'b110;
    for (int b = 0; b < 4; b++) begin
      int own;
      own = (b % 2 == 0) ? 1 : 2;
      wait_cmd();
      check("rr_addr", 64'(mem_cmd_addr), (own == 1) ? 64'h1000 : 64'h2000);
      check("rr_len", 64'(mem_cmd_len), 64'd3);
      accept_cmd(own);
      if (b == 3) req_valid = '0;
      read_data(own, 4, 16'(16'h1000 * own + 16 * b));
    end

    // VGA and INS together: VGA first, INS command two cycles after VGA done.
    tick();
    req_addr[0]  = 25'h0000100;
    req_len[0]   = 4'd1;
    req_write[0] = 1'b1;
    req_addr[1]  = 25'h0000200;
    req_len[1]   = 4'd0;
    req_valid    = 3'b011;
    @(negedge main_clk);
    check("lat_n", 64'(mem_cmd_valid), 64'd0);
    @(negedge main_clk);
    check("lat_n1", 64'(mem_cmd_valid), 64'd1);
    check("vga_addr", 64'(mem_cmd_addr), 64'h100);
    check("vga_write_ignored", 64'(mem_cmd_write), 64'd0);
    accept_cmd(0);
    req_valid[0] = 1'b0;
    req_write[0] = 1'b0;
    read_data(0, 2, 16'hA000);
    @(negedge main_clk);
    check("gap_m1", 64'(mem_cmd_valid), 64'd0);
    @(negedge main_clk);
    check("gap_m2", 64'(mem_cmd_valid), 64'd1);
    check("ins_addr", 64'(mem_cmd_addr), 64'h200);
    accept_cmd(1);
    req_valid = '0;
    read_data(1, 1, 16'hB000);

    // DAT 16-word write with mem_wr_accept toggling.
    tick();
    req_addr[2]    = 25'h0123456;
    req_write[2]   = 1'b1;
    req_len[2]     = 4'd15;
    req_wr_data[2] = 16'h5000;
    req_valid      = 3'b100;
    wait_cmd();
    check("wr_cmd_addr", 64'(mem_cmd_addr), 64'h0123456);
    check("wr_cmd_write", 64'(mem_cmd_write), 64'd1);
    check("wr_cmd_len", 64'(mem_cmd_len), 64'd15);
    accept_cmd(2);
    req_valid = '0;
    write_data(2, 16, 16'h5000);
    req_write[2] = 1'b0;

    // Command held through a 10-cycle stall.
    tick();
    req_addr[1] = 25'h1ABCDEF;
    req_len[1]  = 4'd7;
    req_valid   = 3'b010;
    wait_cmd();
    for (int i = 0; i < 10; i++) begin
      tick();
      @(negedge main_clk);
      check("stall_valid", 64'(mem_cmd_valid), 64'd1);
      check("stall_addr", 64'(mem_cmd_addr), 64'h1ABCDEF);
      check("stall_len", 64'(mem_cmd_len), 64'd7);
      check("stall_no_ready", 64'(req_ready), 64'd0);
    end
    accept_cmd(1);
    req_valid = '0;
    read_data(1, 8, 16'hC000);

    // Spurious controller strobes while idle.
    tick();
    mem_rd_valid  = 1'b1;
    mem_done      = 1'b1;
    mem_wr_accept = 1'b1;
    mem_rd_data   = 16'hDEAD;
    for (int i = 0; i < 3; i++) begin
      @(negedge main_clk);
      check("idle_strobes", 64'({rd_valid, done, wr_accept, mem_cmd_valid}), 64'd0);
      check("idle_state", 64'(dut.state_q), 64'(ARB_IDLE));
      tick();
    end
    mem_rd_valid  = 1'b0;
    mem_done      = 1'b0;
    mem_wr_accept = 1'b0;
    mem_rd_data   = '0;

    // Reset after 2 of 8 VGA read words.
    tick();
    req_addr[0] = 25'h0000777;
    req_len[0]  = 4'd7;
    req_valid   = 3'b001;
    wait_cmd();
    accept_cmd(0);
    req_valid = '0;
    for (int i = 0; i < 2; i++) begin
      tick();
      mem_rd_valid = 1'b1;
      mem_rd_data  = 16'hE000 + 16'(i);
      rd_q.push_back('{0, 16'hE000 + 16'(i)});
    end
    tick();
    mem_rd_valid = 1'b0;
    mem_rd_data  = '0;
    reset        = 1'b1;
    req_addr[1]  = 25'h0000A11;
    req_addr[2]  = 25'h0000D22;
    req_len[1]   = 4'd0;
    req_len[2]   = 4'd0;
    req_valid    = 3'b110;
    tick();
    reset = 1'b0;
    @(negedge main_clk);
    check_all_zero("mid_reset");
    check("mid_reset_state", 64'(dut.state_q), 64'(ARB_IDLE));
    wait_cmd();
    check("tie_after_reset_addr", 64'(mem_cmd_addr), 64'hA11);
    accept_cmd(1);
    req_valid = '0;
    read_data(1, 1, 16'hF000);

    repeat (3) tick();
    check("grant_q_empty", 64'(grant_q.size()), 64'd0);
    check("rd_q_empty", 64'(rd_q.size()), 64'd0);
    check("wr_q_empty", 64'(wr_q.size()), 64'd0);
    check("done_q_empty", 64'(done_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
